// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcodes, ALUOp codes, mux selects and control FSM states
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Shared with ALU_Control, which decodes funct when ALUOp selects it
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SIGNEXT = 2'b10;
    localparam logic [1:0] SRCB_SHIFTED = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_RWB     = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_ADDIEX  = 4'd11,
        ST_ADDIWB  = 4'd12,
        ST_ILLEGAL = 4'd13,
        ST_FAULT   = 4'd14
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Main control FSM of the multicycle MIPS datapath with mem watchdog
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       fault,
    output logic [3:0] state_dbg
);

    localparam logic [7:0] C_TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_is_store;
    logic [7:0] r_wait_cnt;
    logic       w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // lw/sw class is captured at decode so MEMADR ignores later IR changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_is_store <= (opcode == OP_SW);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if ((w_next != r_state) && is_wait_state(w_next)) begin
            r_wait_cnt <= 8'd0;
        end else if (is_wait_state(r_state) && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == C_TO_LAST) && !mem_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = ST_EXEC;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    default:      w_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR:  w_next = r_is_store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (mem_ready)      w_next = ST_MEMWB;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_MEMWR: begin
                if (mem_ready)      w_next = ST_FETCH;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB, ST_ILLEGAL:
                        w_next = ST_FETCH;
            ST_EXEC:    w_next = ST_RWB;
            ST_ADDIEX:  w_next = ST_ADDIWB;
            ST_FAULT:   w_next = ST_FAULT;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        fault       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_SHIFTED;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SIGNEXT;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            ST_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Scoreboard bench for multicycle_control (TIMEOUT = 4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
        logic [1:0] PCSource;
        logic [1:0] ALUOp;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       RegWrite, RegDst, MemtoReg, instr_done, illegal_op, fault;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    out_t       act;

    multicycle_control #(.TIMEOUT(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .mem_req     (act.mem_req),
        .MemRead     (act.MemRead),
        .MemWrite    (act.MemWrite),
        .IorD        (act.IorD),
        .IRWrite     (act.IRWrite),
        .PCWrite     (act.PCWrite),
        .PCWriteCond (act.PCWriteCond),
        .PCSource    (act.PCSource),
        .ALUOp       (act.ALUOp),
        .ALUSrcA     (act.ALUSrcA),
        .ALUSrcB     (act.ALUSrcB),
        .RegWrite    (act.RegWrite),
        .RegDst      (act.RegDst),
        .MemtoReg    (act.MemtoReg),
        .instr_done  (act.instr_done),
        .illegal_op  (act.illegal_op),
        .fault       (act.fault),
        .state_dbg   (act.st)
    );

    always #5 clk = ~clk;

    out_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    drv_done = 1'b0;

    // Expected outputs per state, written from the control table
    function automatic out_t spec_out(input int st, input logic rdy);
        out_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            1:  begin o.mem_req = 1; o.MemRead = 1; o.ALUSrcB = 2'b01;
                      o.IRWrite = rdy; o.PCWrite = rdy; end
            2:  o.ALUSrcB = 2'b11;
            3:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            4:  begin o.mem_req = 1; o.MemRead = 1; o.IorD = 1; end
            5:  begin o.RegWrite = 1; o.MemtoReg = 1; o.instr_done = 1; end
            6:  begin o.mem_req = 1; o.MemWrite = 1; o.IorD = 1; o.instr_done = rdy; end
            7:  begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
            8:  begin o.RegWrite = 1; o.RegDst = 1; o.instr_done = 1; end
            9:  begin o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCWriteCond = 1;
                      o.PCSource = 2'b01; o.instr_done = 1; end
            10: begin o.PCWrite = 1; o.PCSource = 2'b10; o.instr_done = 1; end
            11: begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            12: begin o.RegWrite = 1; o.instr_done = 1; end
            13: begin o.illegal_op = 1; o.instr_done = 1; end
            14: o.fault = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input string tag, input logic rst, input logic rdy,
                        input logic [5:0] opc, input int st);
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = rdy;
        opcode    = opc;
        exp_q.push_back(spec_out(st, rdy));
        tag_q.push_back(tag);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got state=%0d bits=%h, expected state=%0d bits=%h",
                         t, act.st, act, e.st, e);
            end
        end
    end

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    initial begin
        for (int i = 0; i < 3; i++) step("reset", 0, 1, LW, 0);
        step("release", 1, 1, LW, 0);

        step("lw_fetch", 1, 1, LW, 1);
        step("lw_decode", 1, 1, LW, 2);
        step("lw_memadr", 1, 1, RT, 3);
        step("lw_memrd", 1, 1, RT, 4);
        step("lw_memwb", 1, 1, RT, 5);

        step("r_fetch", 1, 1, RT, 1);
        step("r_decode", 1, 1, RT, 2);
        step("r_exec", 1, 1, LW, 7);
        step("r_rwb", 1, 1, LW, 8);

        for (int i = 0; i < 3; i++) step("fetch_wait", 1, 0, SW, 1);
        step("fetch_ready_last", 1, 1, SW, 1);
        step("sw_decode", 1, 1, SW, 2);
        step("sw_memadr", 1, 1, LW, 3);
        for (int i = 0; i < 3; i++) step("sw_wait", 1, 0, LW, 6);
        step("sw_ready", 1, 1, LW, 6);

        step("beq_fetch", 1, 1, BQ, 1);
        step("beq_decode", 1, 1, BQ, 2);
        step("beq_branch", 1, 1, BQ, 9);

        step("j_fetch", 1, 1, JP, 1);
        step("j_decode", 1, 1, JP, 2);
        step("j_jump", 1, 1, JP, 10);

        step("addi_fetch", 1, 1, AI, 1);
        step("addi_decode", 1, 1, AI, 2);
        step("addi_ex", 1, 1, AI, 11);
        step("addi_wb", 1, 1, AI, 12);

        step("ill_fetch", 1, 1, BAD, 1);
        step("ill_decode", 1, 1, BAD, 2);
        step("ill_state", 1, 1, BAD, 13);

        step("wd_fetch", 1, 1, LW, 1);
        step("wd_decode", 1, 1, LW, 2);
        step("wd_memadr", 1, 0, LW, 3);
        for (int i = 0; i < 4; i++) step("wd_memrd_wait", 1, 0, LW, 4);
        step("wd_fault", 1, 0, LW, 14);
        step("wd_fault_sticky", 1, 1, LW, 14);
        step("wd_fault_sticky2", 1, 1, LW, 14);
        step("async_reset", 0, 1, LW, 0);
        step("reset_hold", 0, 1, LW, 0);
        step("rerelease", 1, 1, LW, 0);
        step("refetch", 1, 1, LW, 1);

        @(posedge clk);
        @(posedge clk);
        drv_done = 1'b1;
    end

    initial begin
        fork
            wait (drv_done);
            #20000;
        join_any
        n_tests++;
        if (!drv_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: done=%0d pending=%0d, expected done=1 pending=0",
                     drv_done, exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It sits directly upstream of ALU_Control and produces the 2-bit ALUOp that ALU_Control decodes, together with all datapath enables and mux selects.
- Decodes the 6-bit opcode latched in the IR and sequences each instruction over 3-5 states.
- Stalls on a memory ready handshake, with a watchdog that forces a sticky fault state.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ready in a memory state. 0 disables the watchdog. Range 0-255; the counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access in progress
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IorD  out  1  address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded; to ALU_Control
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = signext, 11 = signext<<2
- RegWrite  out  1  register file write
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- instr_done  out  1  one-cycle pulse on the final state of each instruction
- illegal_op  out  1  one-cycle pulse, unknown opcode
- fault  out  1  sticky; watchdog expired
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs 0, state_dbg = 0. The first clock after release moves IDLE -> FETCH.
- Output timing: outputs are decoded combinationally from the registered state. The only input dependency is that qualified writes also require mem_ready. All signals not listed for a state are 0.
- State encodings (state_dbg): IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12, ILLEGAL 13, FAULT 14.
- FETCH:
  - mem_req = 1, MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00.
  - IRWrite, PCWrite = mem_ready; PCSource = 00.
  - Holds while mem_ready = 0. Goes to DECODE when mem_ready = 1.
  - PC therefore increments exactly once per fetch.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - anything else -> ILLEGAL
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD if opcode was lw, MEMWR if sw. The opcode class is registered in DECODE, so IR changes do not matter.
- MEMRD: mem_req = 1, MemRead = 1, IorD = 1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite = 1, RegDst = 0, MemtoReg = 1, instr_done = 1. Next state FETCH.
- MEMWR: mem_req = 1, MemWrite = 1, IorD = 1. Holds until mem_ready. On the ready cycle instr_done = 1 and next state is FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Next state FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1. Next state FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1. Next state FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1. Next state FETCH.
- ILLEGAL: illegal_op = 1, instr_done = 1. Next state FETCH. The instruction is skipped; PC was already incremented.
- Watchdog:
  - The 8-bit wait counter clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle with mem_ready = 0 in those states.
  - If TIMEOUT != 0 and counter == TIMEOUT-1 with mem_ready = 0, next state is FAULT.
  - mem_ready in that same cycle wins (normal advance).
- FAULT: fault = 1, all other outputs 0, mem_req = 0. Left only via rst_n.
- Reset mid-instruction: immediate return to IDLE; the wait counter clears.
- Latency (clk edges, zero wait states, FETCH to FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT (also used by ALU_Control)
  - state enum/localparams
  - ALUSrcB and PCSource select codes
- No sub-module. The state register, next-state logic, output decode and watchdog counter live in one module.

Test Plan:
- Reset and fetch: rst_n low 3 cycles, then high, mem_ready = 1, opcode = 100011 -> state_dbg sequence 0,1,2,3,4,5,1. MEMWB has RegWrite = 1, MemtoReg = 1. instr_done pulses once. ALUOp = 00 throughout.
- R-type into ALU_Control: opcode = 000000 with ALU_Control attached, funct = 100010 -> in EXEC, ALUOp = 10 and ALU_Operation = 0110. In RWB, RegDst = 1, RegWrite = 1.
- Fetch and store wait states: mem_ready low 3 cycles in FETCH -> state holds at 1, PCWrite and IRWrite stay 0 until ready, then pulse once. Same check for sw in MEMWR: MemWrite held for 4 cycles.
- Branch and jump: opcode 000100 -> BRANCH has ALUOp = 01, PCWriteCond = 1, PCSource = 01. Opcode 000010 -> JUMP has PCWrite = 1, PCSource = 10.
- Illegal opcode: opcode = 111111 -> state 13 for 1 cycle, illegal_op = 1, back to FETCH, no RegWrite or MemWrite asserted.
- Watchdog: TIMEOUT = 4, mem_ready held 0 in MEMRD -> FAULT (14) after 4 cycles with fault = 1 sticky. Async rst_n low mid-FAULT -> IDLE and all outputs 0 immediately.
